// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one producer port feeding four independent consumer channels.
// The counter signals cnt0..cnt3 exist only when DEMUX_COUNT_EN is defined.
interface demux4_stream_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             sel1;
  logic             sel0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;
`endif

  if (CNT_W < 1 || WIDTH < 1) begin : g_bad_param
    $error("demux4_stream_if: WIDTH and CNT_W must be at least 1");
  end

  modport slave (
    input  in_data, sel1, sel0, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
`ifdef DEMUX_COUNT_EN
    , output cnt0, cnt1, cnt2, cnt3
`endif
  );

  modport master (
    output in_data, sel1, sel0, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
`ifdef DEMUX_COUNT_EN
    , input cnt0, cnt1, cnt2, cnt3
`endif
  );
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 stream demux with a one-entry holding register per channel; 1-cycle latency, full throughput.
// in_ready stalls only on the addressed channel; optional per-channel accept counters with DEMUX_COUNT_EN.
module demux4_stream #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  demux4_stream_if.slave bus
);
  logic [1:0]       dst;
  logic             in_rdy;
  logic             accept;
  logic [3:0]       drain;
  logic [3:0]       vld_q;
  logic [3:0]       vld_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux4_stream: CNT_W must be at least 1");
  end

  assign dst    = {bus.sel1, bus.sel0};
  // A full channel can still take a word when it drains in the same cycle.
  assign in_rdy = ~vld_q[dst] | bus.out_ready[dst];
  assign accept = bus.in_valid & in_rdy;
  assign drain  = vld_q & bus.out_ready;

  always_comb begin
    vld_d  = vld_q & ~drain;
    data_d = data_q;
    if (accept) begin
      vld_d[dst]  = 1'b1;
      data_d[dst] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= 4'b0000;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d[dst] = cnt_q[dst] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
  assign bus.cnt3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed vector table, corner sequences and a randomized queue-model run.
module tb_demux4_stream;
  localparam int W  = 32;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  demux4_stream_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  demux4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  ordy;
    logic [31:0] dat;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic        chk_d;
    logic [1:0]  exp_ch;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [7];

  logic [W-1:0]  mq [4][$];
  logic [CW-1:0] acc_cnt [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] get_dat(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

`ifdef DEMUX_COUNT_EN
  function automatic logic [CW-1:0] get_cnt(input int k);
    case (k)
      0:       return bus.cnt0;
      1:       return bus.cnt1;
      2:       return bus.cnt2;
      default: return bus.cnt3;
    endcase
  endfunction
`endif

  task automatic set_in(input logic v, input logic [1:0] s, input logic [3:0] ordy, input logic [W-1:0] d);
    bus.in_valid  = v;
    bus.sel1      = s[1];
    bus.sel0      = s[0];
    bus.out_ready = ordy;
    bus.in_data   = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(1'b0, 2'd0, 4'b0000, '0);
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_v;
    logic       exp_r;
    logic       rst_now;
    int         d;

    checks   = 0;
    failures = 0;

    tbl[0] = '{1'b1, 2'd2, 4'b0000, 32'hA5, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA5};
    tbl[1] = '{1'b1, 2'd2, 4'b0000, 32'hB6, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5};
    tbl[2] = '{1'b1, 2'd0, 4'b0000, 32'h11, 1'b1, 4'b0101, 1'b1, 2'd0, 32'h11};
    tbl[3] = '{1'b1, 2'd3, 4'b0000, 32'h33, 1'b1, 4'b1101, 1'b1, 2'd0, 32'h11};
    tbl[4] = '{1'b1, 2'd0, 4'b0000, 32'h22, 1'b0, 4'b1101, 1'b1, 2'd3, 32'h33};
    tbl[5] = '{1'b1, 2'd0, 4'b0001, 32'h22, 1'b1, 4'b1101, 1'b1, 2'd0, 32'h22};
    tbl[6] = '{1'b0, 2'd1, 4'b1111, 32'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00};

    // reset state
    reset = 1'b0;
    set_in(1'b0, 2'd0, 4'b0000, '0);
    cycle();
    cycle();
    chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    reset = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'h1);

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].v, tbl[i].sel, tbl[i].ordy, W'(tbl[i].dat));
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].chk_d)
        chk($sformatf("tbl%0d_out_data", i), 64'(get_dat(int'(tbl[i].exp_ch))), 64'(tbl[i].exp_dat));
    end

    // back-to-back stream to ch1
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 2'd1, 4'b0010, W'(i));
      #1;
      chk($sformatf("stream%0d_in_ready", i), 64'(bus.in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_data1", i), 64'(bus.out_data1), 64'(i));
      chk($sformatf("stream%0d_valid", i), 64'(bus.out_valid), 64'b0010);
    end
    set_in(1'b0, 2'd1, 4'b0010, '0);
    cycle();
    chk("stream_drained", 64'(bus.out_valid), 64'h0);

    // all channels full, then mid-transfer reset with a pending accept
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 2'(k), 4'b0000, W'(32'hC0 + k));
      cycle();
    end
    chk("all_full", 64'(bus.out_valid), 64'hF);
    reset = 1'b0;
    set_in(1'b1, 2'd2, 4'b1111, W'(32'hEE));
    cycle();
    reset = 1'b1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'h0);
`ifdef DEMUX_COUNT_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("midreset_cnt%0d", k), 64'(get_cnt(k)), 64'h0);
`endif
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 2'(k), 4'b0000, '0);
      #1;
      chk($sformatf("postreset_in_ready%0d", k), 64'(bus.in_ready), 64'h1);
    end

`ifdef DEMUX_COUNT_EN
    // counter wrap: 17 accepts to ch1 with CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 2'd1, 4'b0010, W'(i));
      cycle();
    end
    set_in(1'b0, 2'd0, 4'b1111, '0);
    cycle();
    chk("wrap_cnt1", 64'(bus.cnt1), 64'h1);
    chk("wrap_cnt0", 64'(bus.cnt0), 64'h0);
    chk("wrap_cnt2", 64'(bus.cnt2), 64'h0);
    chk("wrap_cnt3", 64'(bus.cnt3), 64'h0);
`endif

    // randomized run against a per-channel queue model (capacity one word each)
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      acc_cnt[k] = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++)
        exp_v[k] = (mq[k].size() != 0);
      chk("rnd_out_valid", 64'(bus.out_valid), 64'(exp_v));
      for (int k = 0; k < 4; k++) begin
        if (exp_v[k])
          chk($sformatf("rnd_data%0d", k), 64'(get_dat(k)), 64'(mq[k][0]));
`ifdef DEMUX_COUNT_EN
        chk($sformatf("rnd_cnt%0d", k), 64'(get_cnt(k)), 64'(acc_cnt[k]));
`endif
      end

      rst_now = ($urandom_range(0, 499) == 0);
      reset   = ~rst_now;
      set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom), W'($urandom));
      #1;
      d     = {30'd0, bus.sel1, bus.sel0};
      exp_r = (mq[d].size() == 0) || bus.out_ready[d];
      if (rst_now) begin
        for (int k = 0; k < 4; k++) begin
          mq[k].delete();
          acc_cnt[k] = '0;
        end
      end else begin
        chk("rnd_in_ready", 64'(bus.in_ready), 64'(exp_r));
        for (int k = 0; k < 4; k++)
          if (mq[k].size() != 0 && bus.out_ready[k])
            void'(mq[k].pop_front());
        if (bus.in_valid && exp_r) begin
          mq[d].push_back(bus.in_data);
          acc_cnt[d] = acc_cnt[d] + 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux4_stream.md
DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 Parameter WIDTH, default 64, data width of each channel in bits.
REQ-002 Parameter CNT_W, default 16, width of each per-channel transfer counter (used only with DEMUX_COUNT_EN).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with the ports below.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 in_data  input  WIDTH  word offered by the upstream producer.
REQ-007 sel1  input  1  destination select, MSB.
REQ-008 sel0  input  1  destination select, LSB.
REQ-009 in_valid  input  1  in_data, sel1 and sel0 are valid this cycle.
REQ-010 in_ready  output  1  the block accepts the offered word this cycle.
REQ-011 out_data0..out_data3  output  WIDTH each  held word for channels 0..3.
REQ-012 out_valid  output  4  bit k set: channel k holds a valid word.
REQ-013 out_ready  input  4  bit k set: channel k consumer takes the word this cycle.
REQ-014 cnt0..cnt3  output  CNT_W each  accepted-word counters; present only with DEMUX_COUNT_EN.

Function
REQ-015 Destination index d = {sel1, sel0}: 00 selects ch0, 01 selects ch1, 10 selects ch2, 11 selects ch3.
REQ-016 Each channel SHALL have a one-entry holding register (data plus valid flag); there is no other storage.
REQ-017 in_ready = ~out_valid[d] | out_ready[d], combinational from sel1, sel0, out_valid and out_ready; it SHALL NOT depend on in_valid.
REQ-018 Accept = in_valid & in_ready; on accept, in_data SHALL load into channel d's register and out_valid[d] SHALL be 1 in the next cycle (latency 1 cycle).
REQ-019 Drain of channel k = out_valid[k] & out_ready[k]; without a simultaneous accept to k, out_valid[k] SHALL clear in the next cycle.
REQ-020 Drain of k and accept to k in the same cycle: the register SHALL take the new word and out_valid[k] SHALL remain 1 (full-throughput pass).
REQ-021 Channels SHALL be independent: a stalled channel blocks only words addressed to it; drains on other channels proceed in the same cycle.
REQ-022 out_data[k] SHALL hold its value while out_valid[k]=1 and out_ready[k]=0; it is don't-care when out_valid[k]=0.
REQ-023 A word that is offered but not accepted SHALL NOT alter any state; the producer may change sel1/sel0 while in_valid=1 and in_ready=0.
REQ-024 Per channel, each accepted word SHALL appear exactly once, in acceptance order; there is no loss and no duplication.

Reset
REQ-025 While reset=0 at a rising edge, out_valid SHALL become 0000, and counters (if present) SHALL become 0.
REQ-026 out_data registers need not reset; they are don't-care while the matching out_valid bit is 0.
REQ-027 A reset asserted mid-transfer SHALL discard all held words; accept and drain are ignored in that cycle.
REQ-028 in_ready while reset=0 is don't-care; in the first cycle after release it SHALL be 1.

Configuration
REQ-029 Macro DEMUX_COUNT_EN defined: cnt0..cnt3 exist; cnt[k] increments by 1 on each accept to k and wraps from 2^CNT_W-1 to 0; a drain does not affect the count.
REQ-030 DEMUX_COUNT_EN undefined: cnt ports and counter logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then offer 0xA5 with sel=10 and out_ready=0000 -> next cycle out_valid=0100, out_data2=0xA5; a second offer to ch2 sees in_ready=0.
REQ-032 Back-to-back stream to ch1 of 1,2,3,4 with out_ready[1]=1 -> in_ready stays 1, out_data1 shows 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance.
REQ-033 ch0 full and stalled, then offer to ch3 -> ch3 word accepted; ch0 word held unchanged until out_ready[0]=1.
REQ-034 All four channels full, reset=0 for one cycle -> out_valid=0000, counters=0, in_ready=1 the following cycle.
REQ-035 DEMUX_COUNT_EN with CNT_W=4: 17 accepts to ch1 -> cnt1 reads 1 (wrapped); cnt0, cnt2 and cnt3 read 0.
REQ-036 Randomized valid/ready/sel over 10000 cycles against a scoreboard -> per-channel order preserved; no loss and no duplication.
